// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA raster timing generator: the default
// 640x480@60 timing numbers, the per-clock pulse bundle, and two elaboration
// helpers. One helper sums a dimension's active and porch lengths into a
// total. The other checks that a coordinate width can hold that total minus one.
// No ports (package).
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_CW       = 10;

  // Single-clk event pulses, all qualified by the pixel enable.
  typedef struct packed {
    logic line_start;
    logic frame_start;
    logic vblank_start;
  } pulse_t;

  function automatic int unsigned total_from_porches(input int unsigned active,
                                                     input int unsigned fp,
                                                     input int unsigned sync,
                                                     input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // True when the largest count (total-1) is representable in cw bits.
  function automatic bit cw_fits(input int unsigned cw, input int unsigned total);
    if (cw >= 32) return 1'b1;
    return (total - 1) < (32'd1 << cw);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
// Bundle between the timing generator and its consumers (pixel generator,
// movement logic).
//   en           consumer -> generator, run enable
//   pix_ce       one-clk pulse on the first clk of each pixel
//   h_sync/v_sync sync levels
//   video_on     inside the visible area
//   x, y         raster coordinate, CW bits
//   line_start / frame_start / vblank_start  single-clk event pulses
//   frame_cnt    16-bit frame counter
// Modports: master = generator side, slave = consumer side.
interface vga_timing_gen_if #(parameter int CW = 10);
  logic          en;
  logic          pix_ce;
  logic          h_sync;
  logic          v_sync;
  logic          video_on;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          vblank_start;
  logic [15:0]   frame_cnt;

  modport master (
    input  en,
    output pix_ce, h_sync, v_sync, video_on, x, y,
           line_start, frame_start, vblank_start, frame_cnt
  );

  modport slave (
    output en,
    input  pix_ce, h_sync, v_sync, video_on, x, y,
           line_start, frame_start, vblank_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen_pix_ce_gen.sv
// pix_ce_gen
// Divides the system clock down to the pixel rate. The div counter runs
// 0..CLK_DIV-1 while en is high and freezes when en is low.
// Ports:
//   clk, rst_n  system clock, synchronous active-low reset
//   en          run enable
//   pix_first   combinational: en && div==0 (pixel's first clk, current state)
//   pix_last    combinational: en && div==CLK_DIV-1 (raster advances this clk)
//   pix_ce      registered pix_first, aligned with the top's registered outputs
module pix_ce_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pix_first,
  output logic pix_last,
  output logic pix_ce
);

  // CLK_DIV=1 still gets a 1-bit counter that simply stays at zero.
  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          pix_ce_q, pix_ce_d;

  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
    pix_first = en && (div_q == '0);
    pix_last  = en && (div_q == DIV_LAST);
    pix_ce_d  = pix_first;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
    end
  end

  assign pix_ce = pix_ce_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator on a single system clock. Every
// output is a registered decode of the current (div, h, v) state, so outputs
// lag the counters by one clk.
// Ports:
//   clk, rst_n  system clock, synchronous active-low reset
//   vga         vga_timing_gen_if.master (en in; pix_ce, syncs, video_on,
//               x, y, line/frame/vblank pulses, frame_cnt out)
// Configuration macro: VGA_TIMING_FRAME_CNT_EN. When it is defined, the
// design includes the 16-bit frame counter. Otherwise frame_cnt is tied to 0.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned CW       = DEF_CW
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = total_from_porches(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = total_from_porches(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Sync windows are closed ranges [START, LAST] so no constant ever needs
  // to hold H_TOTAL itself.
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_IDLE  = ~HS_POL;
  localparam logic          VS_IDLE  = ~VS_POL;

  if (CLK_DIV == 0) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (!cw_fits(CW, H_TOTAL) || !cw_fits(CW, V_TOTAL)) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  logic pix_first, pix_last, pix_ce;

  pix_ce_gen #(.CLK_DIV(CLK_DIV)) u_pix_ce_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (vga.en),
    .pix_first (pix_first),
    .pix_last  (pix_last),
    .pix_ce    (pix_ce)
  );

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic          video_on_q, video_on_d;
  pulse_t        pulse_q, pulse_d;

  // Raster counters step on the last clk of each pixel; v steps on h wrap.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_last) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Output decode; while stopped the levels and coordinate hold and the
  // pulses drop.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    h_sync_d   = h_sync_q;
    v_sync_d   = v_sync_q;
    video_on_d = video_on_q;
    pulse_d    = '0;
    if (vga.en) begin
      x_d        = h_q;
      y_d        = v_q;
      h_sync_d   = (h_q >= HS_START && h_q <= HS_LAST) ? HS_POL : HS_IDLE;
      v_sync_d   = (v_q >= VS_START && v_q <= VS_LAST) ? VS_POL : VS_IDLE;
      video_on_d = (h_q < H_ACT_C) && (v_q < V_ACT_C);
      pulse_d.line_start   = pix_first && (h_q == '0);
      pulse_d.frame_start  = pulse_d.line_start && (v_q == '0);
      pulse_d.vblank_start = pulse_d.line_start && (v_q == V_ACT_C);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q        <= '0;
      v_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      h_sync_q   <= HS_IDLE;
      v_sync_q   <= VS_IDLE;
      video_on_q <= 1'b0;
      pulse_q    <= '0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      x_q        <= x_d;
      y_q        <= y_d;
      h_sync_q   <= h_sync_d;
      v_sync_q   <= v_sync_d;
      video_on_q <= video_on_d;
      pulse_q    <= pulse_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        seen_q, seen_d;

  // The frame_start that follows reset opens frame 0 and does not count.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    seen_d      = seen_q;
    if (pulse_d.frame_start) begin
      seen_d = 1'b1;
      if (seen_q) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      seen_q      <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      seen_q      <= seen_d;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`else
  assign vga.frame_cnt = 16'd0;
`endif

  assign vga.pix_ce       = pix_ce;
  assign vga.h_sync       = h_sync_q;
  assign vga.v_sync       = v_sync_q;
  assign vga.video_on     = video_on_q;
  assign vga.x            = x_q;
  assign vga.y            = y_q;
  assign vga.line_start   = pulse_q.line_start;
  assign vga.frame_start  = pulse_q.frame_start;
  assign vga.vblank_start = pulse_q.vblank_start;

endmodule
